// File: rtl/fft_bfly2_pipe.sv
// Radix-2 DIT butterfly, three register stages, with saturation bookkeeping.
//   y1 = round((x1 * 2^ACC_LEN + x2 * W) / 2^s), y2 = round((x1 * 2^ACC_LEN - x2 * W) / 2^s)
//   where s = ACC_LEN + scale. Rounding is half toward +inf and results clip to the
//   DATA_WID range. The whole pipeline advances together on en; when the output
//   register is stalled every stage holds.
module fft_bfly2_pipe #(
  parameter int DATA_WID = 16,
  parameter int WN_WID   = 16,
  parameter int ACC_LEN  = 14,
  parameter int CNT_WID  = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_n_i,
  input  logic                       in_valid_i,
  output logic                       in_ready_o,
  input  logic signed [DATA_WID-1:0] fft_data_re1_i,
  input  logic signed [DATA_WID-1:0] fft_data_im1_i,
  input  logic signed [DATA_WID-1:0] fft_data_re2_i,
  input  logic signed [DATA_WID-1:0] fft_data_im2_i,
  input  logic signed [WN_WID-1:0]   fft_wn_re_i,
  input  logic signed [WN_WID-1:0]   fft_wn_im_i,
  input  logic                       scale_i,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic signed [DATA_WID-1:0] fft_data_re1_o,
  output logic signed [DATA_WID-1:0] fft_data_im1_o,
  output logic signed [DATA_WID-1:0] fft_data_re2_o,
  output logic signed [DATA_WID-1:0] fft_data_im2_o,
  input  logic                       sat_clr_i,
  output logic                       sat_flag_o,
  output logic [CNT_WID-1:0]         sat_cnt_o
);

  // Product width holds a full complex product sum; one extra bit covers x1<<ACC_LEN +/- P
  // plus the rounding constant without overflow.
  localparam int PW = DATA_WID + WN_WID + 1;
  localparam int AW = PW + 1;

  typedef logic signed [AW-1:0] acc_t;

  localparam acc_t ONE     = {{(AW-1){1'b0}}, 1'b1};
  localparam acc_t SAT_MAX = {{(AW-DATA_WID+1){1'b0}}, {(DATA_WID-1){1'b1}}};
  localparam acc_t SAT_MIN = ~SAT_MAX;

  // Round half toward +inf, then arithmetic shift by ACC_LEN (+1 when scaling).
  function automatic acc_t rnd_shift(input acc_t a, input logic sc);
    acc_t half;
    acc_t sum;
    half = sc ? (ONE <<< ACC_LEN) : (ONE <<< (ACC_LEN - 1));
    sum  = a + half;
    return sc ? (sum >>> (ACC_LEN + 1)) : (sum >>> ACC_LEN);
  endfunction

  // Clip to the signed DATA_WID range and report whether clipping happened.
  function automatic logic [DATA_WID-1:0] sat_d(input acc_t v, output logic clip);
    if (v > SAT_MAX) begin
      clip = 1'b1;
      return SAT_MAX[DATA_WID-1:0];
    end else if (v < SAT_MIN) begin
      clip = 1'b1;
      return SAT_MIN[DATA_WID-1:0];
    end else begin
      clip = 1'b0;
      return v[DATA_WID-1:0];
    end
  endfunction

  logic en;

  logic                       s1_vld;
  logic signed [DATA_WID-1:0] s1_x1_re, s1_x1_im, s1_x2_re, s1_x2_im;
  logic signed [WN_WID-1:0]   s1_wn_re, s1_wn_im;
  logic                       s1_scale;

  logic signed [PW-1:0]       x2_re_ext, x2_im_ext, wn_re_ext, wn_im_ext;
  logic signed [PW-1:0]       p_re, p_im;

  logic                       s2_vld;
  logic signed [PW-1:0]       s2_p_re, s2_p_im;
  logic signed [DATA_WID-1:0] s2_x1_re, s2_x1_im;
  logic                       s2_scale;

  acc_t                       x1_re_sh, x1_im_sh, p_re_ext, p_im_ext;
  acc_t                       a_re, a_im, b_re, b_im;
  logic [DATA_WID-1:0]        y1_re_d, y1_im_d, y2_re_d, y2_im_d;
  logic                       clip_y1_re, clip_y1_im, clip_y2_re, clip_y2_im;
  logic                       sat_hit;

  // Single global advance: the output register is free or being drained.
  assign en         = !out_valid_o || out_ready_i;
  assign in_ready_o = en;

  // S1: operand capture.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      s1_vld   <= 1'b0;
      s1_x1_re <= '0;
      s1_x1_im <= '0;
      s1_x2_re <= '0;
      s1_x2_im <= '0;
      s1_wn_re <= '0;
      s1_wn_im <= '0;
      s1_scale <= 1'b0;
    end else if (en) begin
      s1_vld   <= in_valid_i;
      s1_x1_re <= fft_data_re1_i;
      s1_x1_im <= fft_data_im1_i;
      s1_x2_re <= fft_data_re2_i;
      s1_x2_im <= fft_data_im2_i;
      s1_wn_re <= fft_wn_re_i;
      s1_wn_im <= fft_wn_im_i;
      s1_scale <= scale_i;
    end
  end

  // Sign-extend operands to product width so the complex multiply is exact.
  always_comb begin
    x2_re_ext = $signed({{(PW-DATA_WID){s1_x2_re[DATA_WID-1]}}, s1_x2_re});
    x2_im_ext = $signed({{(PW-DATA_WID){s1_x2_im[DATA_WID-1]}}, s1_x2_im});
    wn_re_ext = $signed({{(PW-WN_WID){s1_wn_re[WN_WID-1]}}, s1_wn_re});
    wn_im_ext = $signed({{(PW-WN_WID){s1_wn_im[WN_WID-1]}}, s1_wn_im});
    p_re      = x2_re_ext * wn_re_ext - x2_im_ext * wn_im_ext;
    p_im      = x2_re_ext * wn_im_ext + x2_im_ext * wn_re_ext;
  end

  // S2: full-precision products, x1 and scale travel alongside.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      s2_vld   <= 1'b0;
      s2_p_re  <= '0;
      s2_p_im  <= '0;
      s2_x1_re <= '0;
      s2_x1_im <= '0;
      s2_scale <= 1'b0;
    end else if (en) begin
      s2_vld   <= s1_vld;
      s2_p_re  <= p_re;
      s2_p_im  <= p_im;
      s2_x1_re <= s1_x1_re;
      s2_x1_im <= s1_x1_im;
      s2_scale <= s1_scale;
    end
  end

  // Butterfly sum/difference at accumulator width, then round and clip each component.
  always_comb begin
    x1_re_sh = $signed({{(AW-DATA_WID){s2_x1_re[DATA_WID-1]}}, s2_x1_re}) <<< ACC_LEN;
    x1_im_sh = $signed({{(AW-DATA_WID){s2_x1_im[DATA_WID-1]}}, s2_x1_im}) <<< ACC_LEN;
    p_re_ext = $signed({s2_p_re[PW-1], s2_p_re});
    p_im_ext = $signed({s2_p_im[PW-1], s2_p_im});
    a_re     = x1_re_sh + p_re_ext;
    a_im     = x1_im_sh + p_im_ext;
    b_re     = x1_re_sh - p_re_ext;
    b_im     = x1_im_sh - p_im_ext;
    y1_re_d  = sat_d(rnd_shift(a_re, s2_scale), clip_y1_re);
    y1_im_d  = sat_d(rnd_shift(a_im, s2_scale), clip_y1_im);
    y2_re_d  = sat_d(rnd_shift(b_re, s2_scale), clip_y2_re);
    y2_im_d  = sat_d(rnd_shift(b_im, s2_scale), clip_y2_im);
    sat_hit  = en && s2_vld && (clip_y1_re || clip_y1_im || clip_y2_re || clip_y2_im);
  end

  // S3: registered results; holds while the consumer stalls.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      out_valid_o    <= 1'b0;
      fft_data_re1_o <= '0;
      fft_data_im1_o <= '0;
      fft_data_re2_o <= '0;
      fft_data_im2_o <= '0;
    end else if (en) begin
      out_valid_o    <= s2_vld;
      fft_data_re1_o <= y1_re_d;
      fft_data_im1_o <= y1_im_d;
      fft_data_re2_o <= y2_re_d;
      fft_data_im2_o <= y2_im_d;
    end
  end

  // Sticky flag and saturating event counter; clear wins over a same-cycle hit.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sat_flag_o <= 1'b0;
      sat_cnt_o  <= '0;
    end else if (sat_clr_i) begin
      sat_flag_o <= 1'b0;
      sat_cnt_o  <= '0;
    end else if (sat_hit) begin
      sat_flag_o <= 1'b1;
      if (sat_cnt_o != '1) begin
        sat_cnt_o <= sat_cnt_o + CNT_WID'(1);
      end
    end
  end

endmodule

// File: tb/tb_fft_bfly2_pipe.sv
// Bench for fft_bfly2_pipe: directed vector table, stall/reset sequences and a
// randomized scoreboard against an arithmetic reference model.
module tb_fft_bfly2_pipe;
  localparam int DW      = 16;
  localparam int NW      = 16;
  localparam int AL      = 14;
  localparam int CW      = 4;
  localparam int CNT_MAX = (1 << CW) - 1;
  localparam int DMAX    = (1 << (DW - 1)) - 1;
  localparam int DMIN    = -(1 << (DW - 1));

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic in_ready;
  logic out_valid;
  logic out_ready = 1'b1;
  logic signed [DW-1:0] x1re = '0, x1im = '0, x2re = '0, x2im = '0;
  logic signed [NW-1:0] wre = '0, wim = '0;
  logic scale = 1'b0;
  logic signed [DW-1:0] y1re, y1im, y2re, y2im;
  logic sat_clr = 1'b0;
  logic sat_flag;
  logic [CW-1:0] sat_cnt;

  fft_bfly2_pipe #(.DATA_WID(DW), .WN_WID(NW), .ACC_LEN(AL), .CNT_WID(CW)) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .in_valid_i(in_valid), .in_ready_o(in_ready),
    .fft_data_re1_i(x1re), .fft_data_im1_i(x1im),
    .fft_data_re2_i(x2re), .fft_data_im2_i(x2im),
    .fft_wn_re_i(wre), .fft_wn_im_i(wim), .scale_i(scale),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .fft_data_re1_o(y1re), .fft_data_im1_o(y1im),
    .fft_data_re2_o(y2re), .fft_data_im2_o(y2im),
    .sat_clr_i(sat_clr), .sat_flag_o(sat_flag), .sat_cnt_o(sat_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int x1re; int x1im; int x2re; int x2im; int wre; int wim;
    bit sc; bit clr;
    int y1re; int y1im; int y2re; int y2im;
    bit flag; int cnt;
  } vec_t;

  typedef struct { int y1re; int y1im; int y2re; int y2im; } exp_t;

  exp_t exp_q[$];
  vec_t tbl[9];
  int errors = 0;
  int checks = 0;
  int n_out = 0;
  int sat_model = 0;

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Exact rational result rounded half-up: floor((a + d/2) / d).
  function automatic longint rnd(input longint a, input bit sc);
    longint d, r, q;
    d = longint'(1) << (AL + int'(sc));
    r = a + d / 2;
    q = r / d;
    if (r < 0 && q * d != r) q = q - 1;
    return q;
  endfunction

  function automatic int clamp(input longint v, output bit c);
    c = 1'b0;
    if (v > DMAX) begin c = 1'b1; return DMAX; end
    if (v < DMIN) begin c = 1'b1; return DMIN; end
    return int'(v);
  endfunction

  function automatic void model(input int a_re, input int a_im, input int b_re, input int b_im,
                                input int w_re, input int w_im, input bit sc,
                                output exp_t e, output bit clip);
    longint pre, pim, base_re, base_im;
    bit c0, c1, c2, c3;
    pre     = longint'(b_re) * w_re - longint'(b_im) * w_im;
    pim     = longint'(b_re) * w_im + longint'(b_im) * w_re;
    base_re = longint'(a_re) * (longint'(1) << AL);
    base_im = longint'(a_im) * (longint'(1) << AL);
    e.y1re  = clamp(rnd(base_re + pre, sc), c0);
    e.y1im  = clamp(rnd(base_im + pim, sc), c1);
    e.y2re  = clamp(rnd(base_re - pre, sc), c2);
    e.y2im  = clamp(rnd(base_im - pim, sc), c3);
    clip    = c0 | c1 | c2 | c3;
  endfunction

  // Scoreboard: push model results on acceptance, compare whenever a result is presented.
  always @(negedge clk) begin
    exp_t e;
    bit c;
    if (!rst_n) begin
      exp_q.delete();
    end else begin
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: actual=valid beat required=no beat");
        end else begin
          check("sb_y1_re", y1re, exp_q[0].y1re);
          check("sb_y1_im", y1im, exp_q[0].y1im);
          check("sb_y2_re", y2re, exp_q[0].y2re);
          check("sb_y2_im", y2im, exp_q[0].y2im);
          if (out_ready) begin
            void'(exp_q.pop_front());
            n_out++;
          end
        end
      end
      if (in_valid && in_ready) begin
        model(x1re, x1im, x2re, x2im, wre, wim, scale, e, c);
        exp_q.push_back(e);
        if (c) sat_model++;
      end
    end
  end

  function automatic int rnd_d();
    case ($urandom % 5)
      0: return DMAX;
      1: return DMIN;
      2: return int'($urandom_range(0, 200)) - 100;
      default: return int'($urandom_range(0, 65535)) - 32768;
    endcase
  endfunction

  function automatic int rnd_w();
    case ($urandom % 4)
      0: return 16384;
      1: return -16384;
      2: return int'($urandom_range(0, 65535)) - 32768;
      default: return int'($urandom_range(0, 32768)) - 16384;
    endcase
  endfunction

  task automatic new_beat(input int kind);
    if (kind == 1) begin
      x1re = DW'(DMAX); x1im = DW'(DMAX); x2re = DW'(DMAX); x2im = DW'(DMAX);
      wre = NW'(16384); wim = '0; scale = 1'b0;
    end else begin
      x1re = DW'(rnd_d()); x1im = DW'(rnd_d()); x2re = DW'(rnd_d()); x2im = DW'(rnd_d());
      wre = NW'(rnd_w()); wim = NW'(rnd_w()); scale = 1'($urandom % 2);
    end
  endtask

  task automatic pulse_clr();
    @(posedge clk); #1;
    sat_clr = 1'b1;
    @(posedge clk); #1;
    sat_clr = 1'b0;
    sat_model = 0;
  endtask

  // mode 0: ready high, 1: ready low in cycles 4-7, 2: random valid/ready, 3: ready low
  task automatic stream(input int nbeats, input int mode, input int kind, input int budget,
                        input string tag);
    int sent = 0;
    int cyc = 0;
    bit acc;
    new_beat(kind);
    while (sent < nbeats && cyc < budget) begin
      in_valid = (mode == 2) ? ($urandom % 4 != 0) : 1'b1;
      case (mode)
        0: out_ready = 1'b1;
        1: out_ready = !(cyc >= 4 && cyc <= 7);
        2: out_ready = ($urandom % 3 != 0);
        default: out_ready = 1'b0;
      endcase
      @(negedge clk);
      check({tag, "_in_ready_rule"}, in_ready, !(out_valid && !out_ready));
      acc = in_valid && in_ready;
      @(posedge clk); #1;
      if (acc) begin
        sent++;
        new_beat(kind);
      end
      cyc++;
    end
    check({tag, "_beats_sent"}, sent, nbeats);
  endtask

  task automatic drain(input string tag);
    int k = 0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    while ((exp_q.size() != 0 || out_valid) && k < 30) begin
      @(posedge clk); #1;
      k++;
    end
    check({tag, "_drain_in_time"}, k < 30, 1);
  endtask

  task automatic send_vec(input vec_t v, input string tag);
    int n = 0;
    if (v.clr) pulse_clr();
    x1re = DW'(v.x1re); x1im = DW'(v.x1im); x2re = DW'(v.x2re); x2im = DW'(v.x2im);
    wre = NW'(v.wre); wim = NW'(v.wim); scale = v.sc;
    in_valid = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    check({tag, "_in_ready"}, in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (out_valid) begin n = i; break; end
    end
    check({tag, "_latency"}, n, 3);
    check({tag, "_y1_re"}, y1re, v.y1re);
    check({tag, "_y1_im"}, y1im, v.y1im);
    check({tag, "_y2_re"}, y2re, v.y2re);
    check({tag, "_y2_im"}, y2im, v.y2im);
    check({tag, "_sat_flag"}, sat_flag, v.flag);
    check({tag, "_sat_cnt"}, sat_cnt, v.cnt);
    @(posedge clk); #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: actual=time limit reached required=finish");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1);
  end

  initial begin
    int nb;
    //         x1re    x1im   x2re    x2im   wre     wim  sc clr  y1re    y1im  y2re y2im    f  cnt
    tbl[0] = '{1000,   0,     500,    0,     16384,  0,      0, 0, 1500,   0,    500, 0,      0, 0};
    tbl[1] = '{10,     20,    0,      100,   0,      -16384, 0, 0, 110,    20,   -90, 20,     0, 0};
    tbl[2] = '{32767,  0,     32767,  0,     16384,  0,      0, 0, 32767,  0,    0,   0,      1, 1};
    tbl[3] = '{32767,  0,     32767,  0,     16384,  0,      1, 0, 32767,  0,    0,   0,      1, 1};
    tbl[4] = '{3,      -3,    0,      0,     16384,  0,      1, 0, 2,      -1,   2,   -1,     1, 1};
    tbl[5] = '{1,      -1,    0,      0,     0,      0,      1, 1, 1,      0,    1,   0,      0, 0};
    tbl[6] = '{0,      0,     1,      0,     8192,   0,      0, 0, 1,      0,    0,   0,      0, 0};
    tbl[7] = '{-32768, 0,     -32768, 0,     16384,  0,      0, 0, -32768, 0,    0,   0,      1, 1};
    tbl[8] = '{0,      -32768, 0,     32767, 16384,  0,      0, 0, 0,      -1,   0,   -32768, 1, 2};

    // Reset values, with a valid beat offered that must not be taken.
    x1re = 16'sd77; in_valid = 1'b1;
    #12;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_sat_flag", sat_flag, 0);
    check("rst_sat_cnt", sat_cnt, 0);
    check("rst_y1_re", y1re, 0);
    check("rst_y2_im", y2im, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++) send_vec(tbl[i], $sformatf("vec%0d", i));

    pulse_clr();
    @(negedge clk);
    check("clr_sat_cnt", sat_cnt, 0);
    check("clr_sat_flag", sat_flag, 0);
    @(posedge clk); #1;

    // Clear asserted on the very edge a saturated beat enters the output stage.
    x1re = DW'(DMAX); x1im = '0; x2re = DW'(DMAX); x2im = '0;
    wre = NW'(16384); wim = '0; scale = 1'b0;
    in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    sat_clr = 1'b1;
    @(posedge clk); #1;
    sat_clr = 1'b0;
    @(negedge clk);
    check("clrpri_out_valid", out_valid, 1);
    check("clrpri_sat_cnt", sat_cnt, 0);
    check("clrpri_sat_flag", sat_flag, 0);
    @(posedge clk); #1;
    send_vec(tbl[2], "after_clr");

    // 8 back-to-back beats with the consumer stalled in cycles 4-7.
    nb = n_out;
    stream(8, 1, 0, 60, "stall");
    drain("stall");
    check("stall_delivered", n_out - nb, 8);

    // Counter must stop at all-ones.
    pulse_clr();
    stream(20, 0, 1, 60, "satrun");
    drain("satrun");
    check("satrun_cnt", sat_cnt, (sat_model > CNT_MAX) ? CNT_MAX : sat_model);
    check("satrun_flag", sat_flag, sat_model > 0);

    // Random traffic against the model.
    pulse_clr();
    nb = n_out;
    stream(300, 2, 0, 3000, "rand");
    drain("rand");
    check("rand_delivered", n_out - nb, 300);
    check("rand_sat_cnt", sat_cnt, (sat_model > CNT_MAX) ? CNT_MAX : sat_model);
    check("rand_sat_flag", sat_flag, sat_model > 0);

    // Reset with three beats in flight.
    stream(3, 3, 0, 10, "inflight");
    check("inflight_out_valid", out_valid, 1);
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", out_valid, 0);
    check("arst_in_ready", in_ready, 1);
    check("arst_y1_re", y1re, 0);
    check("arst_y2_im", y2im, 0);
    check("arst_sat_cnt", sat_cnt, 0);
    in_valid = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    check("arst_hold_valid", out_valid, 0);
    in_valid = 1'b0;
    out_ready = 1'b1;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("post_rst_no_stale", out_valid, 0);
    end
    @(posedge clk); #1;
    send_vec(tbl[1], "post_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
